// File: rtl/vga_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | vga_controller                                                         |
// | Free-running raster timing generator: column/line counters and         |
// | visible-region flags, all registered.                                  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module vga_controller #(
  parameter int ZERO                   = 0,
  parameter int THRESHOLD_HSYNC        = 1024,
  parameter int THRESHOLD_VSYNC        = 768,
  parameter int WHOLE_FRAME_VERTICAL   = 1368,
  parameter int WHOLE_FRAME_HORIZONTAL = 806,
  parameter int COUNTER_SIZE           = 11
) (
  input  logic                    control_clock,
  input  logic                    control_reset_n,
  output logic [COUNTER_SIZE-1:0] counter_out_hsync,
  output logic [COUNTER_SIZE-1:0] counter_out_vsync,
  output logic                    h_sync,
  output logic                    v_sync
);

  localparam logic [COUNTER_SIZE-1:0] c_ZERO   = COUNTER_SIZE'(ZERO);
  localparam logic [COUNTER_SIZE-1:0] c_ONE    = COUNTER_SIZE'(1);
  localparam logic [COUNTER_SIZE-1:0] c_H_LAST = COUNTER_SIZE'(WHOLE_FRAME_VERTICAL - 1);
  localparam logic [COUNTER_SIZE-1:0] c_V_LAST = COUNTER_SIZE'(WHOLE_FRAME_HORIZONTAL - 1);
  // One extra bit so a threshold equal to 2^COUNTER_SIZE stays representable.
  localparam logic [COUNTER_SIZE:0]   c_H_THR  = (COUNTER_SIZE+1)'(THRESHOLD_HSYNC);
  localparam logic [COUNTER_SIZE:0]   c_V_THR  = (COUNTER_SIZE+1)'(THRESHOLD_VSYNC);

  logic [COUNTER_SIZE-1:0] r_h;
  logic [COUNTER_SIZE-1:0] r_v;
  logic                    r_hs;
  logic                    r_vs;

  logic [COUNTER_SIZE-1:0] w_h_next;
  logic [COUNTER_SIZE-1:0] w_v_next;
  logic                    w_h_wrap;
  logic                    w_hs_next;
  logic                    w_vs_next;

  always_comb begin
    w_h_wrap = (r_h == c_H_LAST);
    w_h_next = w_h_wrap ? c_ZERO : (r_h + c_ONE);
    w_v_next = r_v;
    if (w_h_wrap) begin
      w_v_next = (r_v == c_V_LAST) ? c_ZERO : (r_v + c_ONE);
    end
    // Flags follow the next-state counters so they line up with them in time.
    w_hs_next = ({1'b0, w_h_next} < c_H_THR);
    w_vs_next = ({1'b0, w_v_next} < c_V_THR);
  end

  always_ff @(posedge control_clock) begin
    if (!control_reset_n) begin
      r_h  <= c_ZERO;
      r_v  <= c_ZERO;
      r_hs <= 1'b1;
      r_vs <= 1'b1;
    end else begin
      r_h  <= w_h_next;
      r_v  <= w_v_next;
      r_hs <= w_hs_next;
      r_vs <= w_vs_next;
    end
  end

  assign counter_out_hsync = r_h;
  assign counter_out_vsync = r_v;
  assign h_sync            = r_hs;
  assign v_sync            = r_vs;

endmodule
`default_nettype wire

// File: tb/tb_vga_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_vga_controller                                                      |
// | Directed bench: default-size, tiny and medium raster instances.        |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_vga_controller;

  logic clk;
  logic rst_n;

  logic [10:0] a_h, a_v;
  logic        a_hs, a_vs;
  logic [10:0] b_h, b_v;
  logic        b_hs, b_vs;
  logic [4:0]  c_h, c_v;
  logic        c_hs, c_vs;

  int n_chk;
  int n_err;

  // Default 1368 x 806 raster.
  vga_controller u_dut_a (
    .control_clock     (clk),
    .control_reset_n   (rst_n),
    .counter_out_hsync (a_h),
    .counter_out_vsync (a_v),
    .h_sync            (a_hs),
    .v_sync            (a_vs)
  );

  // Tiny raster: 6 clocks per line, 3 lines per frame.
  vga_controller #(
    .THRESHOLD_HSYNC        (4),
    .THRESHOLD_VSYNC        (2),
    .WHOLE_FRAME_VERTICAL   (6),
    .WHOLE_FRAME_HORIZONTAL (3)
  ) u_dut_b (
    .control_clock     (clk),
    .control_reset_n   (rst_n),
    .counter_out_hsync (b_h),
    .counter_out_vsync (b_v),
    .h_sync            (b_hs),
    .v_sync            (b_vs)
  );

  // Medium raster: 24 x 14, thresholds 16 / 12, 5-bit counters.
  vga_controller #(
    .THRESHOLD_HSYNC        (16),
    .THRESHOLD_VSYNC        (12),
    .WHOLE_FRAME_VERTICAL   (24),
    .WHOLE_FRAME_HORIZONTAL (14),
    .COUNTER_SIZE           (5)
  ) u_dut_c (
    .control_clock     (clk),
    .control_reset_n   (rst_n),
    .counter_out_hsync (c_h),
    .counter_out_vsync (c_v),
    .h_sync            (c_hs),
    .v_sync            (c_vs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (a_h !== 11'd0 || a_v !== 11'd0 || a_hs !== 1'b1 || a_vs !== 1'b1) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: got H=%0d V=%0d hs=%b vs=%b, want H=0 V=0 hs=1 vs=1",
                 i, a_h, a_v, a_hs, a_vs);
      end
    end
    rst_n = 1'b1;
    tick();
    n_chk++;
    if (a_h !== 11'd1 || a_v !== 11'd0 || a_hs !== 1'b1 || a_vs !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: got H=%0d V=%0d hs=%b vs=%b, want H=1 V=0 hs=1 vs=1",
               a_h, a_v, a_hs, a_vs);
    end
    n_chk++;
    if (b_h !== 11'd1 || c_h !== 5'd1) begin
      n_err++;
      $display("FAIL reset_release_small: got bH=%0d cH=%0d, want 1 and 1", b_h, c_h);
    end
  endtask

  task automatic test_line_wrap();
    int k;
    int bad;
    k = 0;
    while (a_h !== 11'd1023 && k < 2000) begin tick(); k++; end
    n_chk++;
    if (a_h !== 11'd1023 || a_hs !== 1'b1) begin
      n_err++;
      $display("FAIL h1023: got H=%0d hs=%b, want H=1023 hs=1", a_h, a_hs);
    end
    tick();
    n_chk++;
    if (a_h !== 11'd1024 || a_hs !== 1'b0) begin
      n_err++;
      $display("FAIL h1024: got H=%0d hs=%b, want H=1024 hs=0", a_h, a_hs);
    end
    k = 0;
    while (a_h !== 11'd1367 && k < 2000) begin tick(); k++; end
    n_chk++;
    if (a_h !== 11'd1367 || a_v !== 11'd0 || a_hs !== 1'b0) begin
      n_err++;
      $display("FAIL h1367: got H=%0d V=%0d hs=%b, want H=1367 V=0 hs=0", a_h, a_v, a_hs);
    end
    tick();
    n_chk++;
    if (a_h !== 11'd0 || a_v !== 11'd1 || a_hs !== 1'b1 || a_vs !== 1'b1) begin
      n_err++;
      $display("FAIL line_wrap: got H=%0d V=%0d hs=%b vs=%b, want H=0 V=1 hs=1 vs=1",
               a_h, a_v, a_hs, a_vs);
    end
    // Full line: measure period and check every column's flag and range.
    k = 0;
    bad = 0;
    do begin
      tick();
      k++;
      if (a_h > 11'd1367 || a_hs !== (a_h < 11'd1024)) bad++;
    end while (a_h !== 11'd0 && k < 3000);
    n_chk++;
    if (k != 1368) begin
      n_err++;
      $display("FAIL line_period: got %0d clocks, want 1368", k);
    end
    n_chk++;
    if (bad != 0 || a_v !== 11'd2) begin
      n_err++;
      $display("FAIL line_scan: got %0d bad columns V=%0d, want 0 bad V=2", bad, a_v);
    end
  endtask

  task automatic test_mid_frame_reset();
    int k;
    k = 0;
    while (a_h !== 11'd500 && k < 2000) begin tick(); k++; end
    n_chk++;
    if (a_h !== 11'd500 || a_v !== 11'd2) begin
      n_err++;
      $display("FAIL mid_reset_setup: got H=%0d V=%0d, want H=500 V=2", a_h, a_v);
    end
    rst_n = 1'b0;
    tick();
    n_chk++;
    if (a_h !== 11'd0 || a_v !== 11'd0 || a_hs !== 1'b1 || a_vs !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset: got H=%0d V=%0d hs=%b vs=%b, want H=0 V=0 hs=1 vs=1",
               a_h, a_v, a_hs, a_vs);
    end
    rst_n = 1'b1;
    tick();
    tick();
    n_chk++;
    if (a_h !== 11'd2 || a_v !== 11'd0 || a_hs !== 1'b1 || a_vs !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset_restart: got H=%0d V=%0d hs=%b vs=%b, want H=2 V=0 hs=1 vs=1",
               a_h, a_v, a_hs, a_vs);
    end
  endtask

  task automatic test_small_frame();
    int k;
    int eh;
    int ev;
    int bad;
    k = 0;
    while (!(b_h === 11'd0 && b_v === 11'd0) && k < 40) begin tick(); k++; end
    n_chk++;
    if (b_h !== 11'd0 || b_v !== 11'd0) begin
      n_err++;
      $display("FAIL small_sync: got H=%0d V=%0d, want H=0 V=0", b_h, b_v);
    end
    bad = 0;
    for (int i = 0; i < 36; i++) begin
      eh = i % 6;
      ev = (i / 6) % 3;
      if (b_h !== 11'(eh) || b_v !== 11'(ev) || b_hs !== (eh < 4) || b_vs !== (ev < 2)) begin
        bad++;
        $display("FAIL small_pattern[%0d]: got H=%0d V=%0d hs=%b vs=%b, want H=%0d V=%0d hs=%b vs=%b",
                 i, b_h, b_v, b_hs, b_vs, eh, ev, (eh < 4), (ev < 2));
      end
      tick();
    end
    n_chk++;
    if (bad != 0) n_err++;
    k = 0;
    do begin tick(); k++; end while (!(b_h === 11'd0 && b_v === 11'd0) && k < 100);
    n_chk++;
    if (k != 18) begin
      n_err++;
      $display("FAIL small_frame_period: got %0d clocks, want 18", k);
    end
  endtask

  task automatic test_frame_wrap();
    int k;
    int bad;
    k = 0;
    while (!(c_h === 5'd23 && c_v === 5'd11) && k < 400) begin tick(); k++; end
    n_chk++;
    if (c_h !== 5'd23 || c_v !== 5'd11 || c_hs !== 1'b0 || c_vs !== 1'b1) begin
      n_err++;
      $display("FAIL v_last_visible: got H=%0d V=%0d hs=%b vs=%b, want H=23 V=11 hs=0 vs=1",
               c_h, c_v, c_hs, c_vs);
    end
    tick();
    n_chk++;
    if (c_h !== 5'd0 || c_v !== 5'd12 || c_hs !== 1'b1 || c_vs !== 1'b0) begin
      n_err++;
      $display("FAIL v_edge: got H=%0d V=%0d hs=%b vs=%b, want H=0 V=12 hs=1 vs=0",
               c_h, c_v, c_hs, c_vs);
    end
    k = 0;
    bad = 0;
    while (!(c_h === 5'd23 && c_v === 5'd13) && k < 100) begin
      tick();
      k++;
      if (c_vs !== 1'b0 || c_h > 5'd23 || c_v > 5'd13) bad++;
    end
    n_chk++;
    if (bad != 0 || c_h !== 5'd23 || c_v !== 5'd13) begin
      n_err++;
      $display("FAIL v_blank: got %0d bad cycles ending H=%0d V=%0d, want 0 bad ending H=23 V=13",
               bad, c_h, c_v);
    end
    tick();
    n_chk++;
    if (c_h !== 5'd0 || c_v !== 5'd0 || c_hs !== 1'b1 || c_vs !== 1'b1) begin
      n_err++;
      $display("FAIL frame_wrap: got H=%0d V=%0d hs=%b vs=%b, want H=0 V=0 hs=1 vs=1",
               c_h, c_v, c_hs, c_vs);
    end
    k = 0;
    bad = 0;
    do begin
      tick();
      k++;
      if (c_h > 5'd23 || c_v > 5'd13 || c_hs !== (c_h < 5'd16) || c_vs !== (c_v < 5'd12)) bad++;
    end while (!(c_h === 5'd0 && c_v === 5'd0) && k < 1000);
    n_chk++;
    if (k != 336) begin
      n_err++;
      $display("FAIL frame_period: got %0d clocks, want 336", k);
    end
    n_chk++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL frame_scan: got %0d bad cycles, want 0", bad);
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_line_wrap();
    test_mid_frame_reset();
    test_small_frame();
    test_frame_wrap();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
